// File: rtl/avalon_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM agent between N_HOSTS hosts.
// One grant per transaction (incl. read response), with a bus watchdog.
module avalon_rr_arbiter #(
  parameter int N_HOSTS = 2,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_HOSTS*ADDR_W-1:0] h_address,
  input  logic [N_HOSTS*4-1:0]      h_byteenable,
  input  logic [N_HOSTS-1:0]        h_read,
  input  logic [N_HOSTS-1:0]        h_write,
  input  logic [N_HOSTS*32-1:0]     h_writedata,
  output logic [N_HOSTS-1:0]        h_waitrequest,
  output logic [31:0]               h_readdata,
  output logic [N_HOSTS-1:0]        h_readdatavalid,
  output logic [ADDR_W-1:0]         a_address,
  output logic [3:0]                a_byteenable,
  output logic                      a_read,
  output logic                      a_write,
  output logic [31:0]               a_writedata,
  input  logic                      a_waitrequest,
  input  logic [31:0]               a_readdata,
  input  logic                      a_readdatavalid,
  output logic [N_HOSTS-1:0]        grant,
  output logic                      timeout_err
);

  localparam int PW = $clog2(N_HOSTS);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CLIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PW-1:0] LAST = PW'(N_HOSTS - 1);

  typedef enum logic [1:0] {IDLE, CMD, RESP} state_e;

  state_e             state_q, state_d;
  logic [N_HOSTS-1:0] grant_q, grant_d;
  logic [PW-1:0]      gidx_q, gidx_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               terr_q, terr_d;

  logic [N_HOSTS-1:0] req;
  logic [PW-1:0]      pick;
  logic               found;
  logic               req_g, wr_g, rd_g;
  logic               busy, done, fire;

  assign req   = h_read | h_write;
  assign req_g = req[gidx_q];
  assign wr_g  = h_write[gidx_q];
  assign rd_g  = h_read[gidx_q] & ~wr_g;
  assign busy  = (state_q != IDLE);

  // First requester at or after ptr, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_HOSTS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_HOSTS) idx = idx - N_HOSTS;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  always_comb begin
    done = 1'b0;
    unique case (state_q)
      CMD:  done = !req_g
                 | (!a_waitrequest & (wr_g | a_readdatavalid));
      RESP: done = a_readdatavalid;
      default: done = 1'b0;
    endcase
  end

  assign fire = (TIMEOUT != 0) && busy && (cnt_q == CLIM) && !done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    terr_d  = fire;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = CMD;
          gidx_d  = pick;
          grant_d = N_HOSTS'(1) << pick;
          cnt_d   = '0;
        end
      end
      CMD, RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (done || fire) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (gidx_q == LAST) ? '0 : gidx_q + 1'b1;
        end else if (state_q == CMD && !a_waitrequest) begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_address       = '0;
    a_byteenable    = '0;
    a_writedata     = '0;
    a_read          = 1'b0;
    a_write         = 1'b0;
    h_waitrequest   = req;
    h_readdatavalid = '0;
    h_readdata      = '0;
    if (state_q == CMD && req_g && !fire) begin
      a_address    = h_address[int'(gidx_q)*ADDR_W +: ADDR_W];
      a_byteenable = h_byteenable[int'(gidx_q)*4 +: 4];
      a_writedata  = h_writedata[int'(gidx_q)*32 +: 32];
      a_write      = wr_g;
      a_read       = rd_g;
    end
    if (busy) begin
      h_readdata              = a_readdata;
      h_readdatavalid[gidx_q] = a_readdatavalid;
      if (state_q == CMD) h_waitrequest[gidx_q] = a_waitrequest;
      // Watchdog completes the stuck transaction toward the host.
      if (fire) begin
        h_waitrequest[gidx_q] = 1'b0;
        h_readdatavalid[gidx_q] = 1'b0;
        if (state_q == RESP || rd_g) begin
          h_readdatavalid[gidx_q] = 1'b1;
          h_readdata = 32'hFFFF_FFFF;
        end
      end
    end
  end

  assign grant       = grant_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_avalon_rr_arbiter.sv
// Directed bench for avalon_rr_arbiter (2 hosts, TIMEOUT = 8).
module tb_avalon_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [63:0] h_address;
  logic [7:0]  h_byteenable;
  logic [1:0]  h_read, h_write;
  logic [63:0] h_writedata;
  logic [1:0]  h_waitrequest;
  logic [31:0] h_readdata;
  logic [1:0]  h_readdatavalid;
  logic [31:0] a_address;
  logic [3:0]  a_byteenable;
  logic        a_read, a_write;
  logic [31:0] a_writedata;
  logic        a_waitrequest;
  logic [31:0] a_readdata;
  logic        a_readdatavalid;
  logic [1:0]  grant;
  logic        timeout_err;

  int nchk = 0;
  int nerr = 0;

  avalon_rr_arbiter #(.N_HOSTS(2), .ADDR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .h_address(h_address), .h_byteenable(h_byteenable),
    .h_read(h_read), .h_write(h_write), .h_writedata(h_writedata),
    .h_waitrequest(h_waitrequest), .h_readdata(h_readdata),
    .h_readdatavalid(h_readdatavalid),
    .a_address(a_address), .a_byteenable(a_byteenable),
    .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata),
    .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
    .a_readdatavalid(a_readdatavalid),
    .grant(grant), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #2;
    nchk++;
    if ({grant, a_read, a_write, timeout_err} !== 5'b0) begin
      nerr++;
      $display("FAIL rst_ctl: got g=%b r=%b w=%b t=%b exp 0",
               grant, a_read, a_write, timeout_err);
    end
    nchk++;
    if ({h_readdatavalid, h_readdata} !== 34'b0) begin
      nerr++;
      $display("FAIL rst_resp: got rdv=%b rd=%h exp 0",
               h_readdatavalid, h_readdata);
    end
    h_read = 2'b11;
    #1;
    nchk++;
    if (h_waitrequest !== 2'b11) begin
      nerr++;
      $display("FAIL rst_wait: got %b exp 11", h_waitrequest);
    end
    h_read = 2'b00;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_alternate;
    logic [1:0]  exp;
    logic [31:0] ea;
    h_read = 2'b11;
    h_address = {32'h2000_0010, 32'h1000_0000};
    a_waitrequest = 1'b0;
    a_readdatavalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      ea  = (k % 2 == 0) ? 32'h1000_0000 : 32'h2000_0010;
      #1;
      nchk++;
      if ({grant, h_waitrequest} !== 4'b0011) begin
        nerr++;
        $display("FAIL alt_idle%0d: got g=%b w=%b exp 00/11",
                 k, grant, h_waitrequest);
      end
      tick;
      nchk++;
      if (grant !== exp || a_read !== 1'b1 || a_address !== ea) begin
        nerr++;
        $display("FAIL alt_cmd%0d: got g=%b r=%b a=%h exp %b 1 %h",
                 k, grant, a_read, a_address, exp, ea);
      end
      nchk++;
      if (h_waitrequest !== ~exp || h_readdatavalid !== 2'b00) begin
        nerr++;
        $display("FAIL alt_cmdw%0d: got w=%b v=%b exp %b 00",
                 k, h_waitrequest, h_readdatavalid, ~exp);
      end
      tick;
      nchk++;
      if (a_read !== 1'b0 || h_waitrequest !== 2'b11
          || h_readdatavalid !== 2'b00 || grant !== exp) begin
        nerr++;
        $display("FAIL alt_resp%0d: got r=%b w=%b v=%b g=%b",
                 k, a_read, h_waitrequest, h_readdatavalid, grant);
      end
      tick;
      a_readdatavalid = 1'b1;
      a_readdata = 32'hA000_0000 + k;
      #1;
      nchk++;
      if (h_readdatavalid !== exp || h_readdata !== 32'hA000_0000 + k) begin
        nerr++;
        $display("FAIL alt_data%0d: got v=%b d=%h exp %b %h",
                 k, h_readdatavalid, h_readdata, exp, 32'hA000_0000 + k);
      end
      tick;
      a_readdatavalid = 1'b0;
    end
    h_read = 2'b00;
  endtask

  task automatic test_write;
    h_write = 2'b01;
    h_address[31:0] = 32'h0000_0100;
    h_writedata[31:0] = 32'hDEAD_BEEF;
    h_byteenable = 8'h0F;
    a_waitrequest = 1'b0;
    #1;
    nchk++;
    if (grant !== 2'b00 || a_write !== 1'b0 || h_waitrequest !== 2'b01) begin
      nerr++;
      $display("FAIL wr_idle: got g=%b w=%b hw=%b exp 00 0 01",
               grant, a_write, h_waitrequest);
    end
    tick;
    nchk++;
    if (grant !== 2'b01 || a_write !== 1'b1 || a_read !== 1'b0
        || h_waitrequest !== 2'b00) begin
      nerr++;
      $display("FAIL wr_cmd: got g=%b w=%b r=%b hw=%b exp 01 1 0 00",
               grant, a_write, a_read, h_waitrequest);
    end
    nchk++;
    if (a_address !== 32'h100 || a_writedata !== 32'hDEAD_BEEF
        || a_byteenable !== 4'hF) begin
      nerr++;
      $display("FAIL wr_route: got a=%h d=%h be=%h exp 100 deadbeef f",
               a_address, a_writedata, a_byteenable);
    end
    tick;
    h_write = 2'b00;
    #1;
    nchk++;
    if (grant !== 2'b00 || a_write !== 1'b0 || h_waitrequest !== 2'b00) begin
      nerr++;
      $display("FAIL wr_done: got g=%b w=%b hw=%b exp 00 0 00",
               grant, a_write, h_waitrequest);
    end
  endtask

  task automatic test_stall;
    h_read = 2'b10;
    h_address[63:32] = 32'h0000_0040;
    a_waitrequest = 1'b1;
    #1;
    nchk++;
    if (h_waitrequest !== 2'b10 || grant !== 2'b00) begin
      nerr++;
      $display("FAIL st_idle: got w=%b g=%b exp 10 00", h_waitrequest, grant);
    end
    tick;
    nchk++;
    if (grant !== 2'b10 || a_read !== 1'b1 || a_address !== 32'h40
        || h_waitrequest !== 2'b10) begin
      nerr++;
      $display("FAIL st_cmd: got g=%b r=%b a=%h w=%b exp 10 1 40 10",
               grant, a_read, a_address, h_waitrequest);
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      nchk++;
      if (h_waitrequest !== 2'b10 || h_readdatavalid !== 2'b00) begin
        nerr++;
        $display("FAIL st_wait%0d: got w=%b v=%b exp 10 00",
                 i, h_waitrequest, h_readdatavalid);
      end
    end
    tick;
    a_waitrequest = 1'b0;
    #1;
    nchk++;
    if (h_waitrequest !== 2'b00 || a_read !== 1'b1) begin
      nerr++;
      $display("FAIL st_acc: got w=%b r=%b exp 00 1", h_waitrequest, a_read);
    end
    tick;
    h_read = 2'b00;
    a_readdatavalid = 1'b1;
    a_readdata = 32'h1234_5678;
    #1;
    nchk++;
    if (h_readdatavalid !== 2'b10 || h_readdata !== 32'h1234_5678
        || grant !== 2'b10) begin
      nerr++;
      $display("FAIL st_data: got v=%b d=%h g=%b exp 10 12345678 10",
               h_readdatavalid, h_readdata, grant);
    end
    tick;
    a_readdatavalid = 1'b0;
    #1;
    nchk++;
    if (grant !== 2'b00) begin
      nerr++;
      $display("FAIL st_done: got g=%b exp 00", grant);
    end
  endtask

  task automatic test_timeout;
    h_read = 2'b01;
    h_address[31:0] = 32'h0000_0300;
    a_waitrequest = 1'b1;
    a_readdatavalid = 1'b0;
    tick;
    nchk++;
    if (grant !== 2'b01) begin
      nerr++;
      $display("FAIL to_grant: got %b exp 01", grant);
    end
    for (int i = 1; i < 7; i++) begin
      tick;
      nchk++;
      if ({timeout_err, h_waitrequest} !== 3'b001) begin
        nerr++;
        $display("FAIL to_wait%0d: got t=%b w=%b exp 0 01",
                 i, timeout_err, h_waitrequest);
      end
    end
    tick;
    nchk++;
    if (h_waitrequest !== 2'b00 || h_readdatavalid !== 2'b01
        || h_readdata !== 32'hFFFF_FFFF) begin
      nerr++;
      $display("FAIL to_fill: got w=%b v=%b d=%h exp 00 01 ffffffff",
               h_waitrequest, h_readdatavalid, h_readdata);
    end
    nchk++;
    if (a_read !== 1'b0 || timeout_err !== 1'b0) begin
      nerr++;
      $display("FAIL to_drop: got r=%b t=%b exp 0 0", a_read, timeout_err);
    end
    tick;
    h_read = 2'b11;
    h_address[63:32] = 32'h0000_0500;
    #1;
    nchk++;
    if (timeout_err !== 1'b1 || grant !== 2'b00) begin
      nerr++;
      $display("FAIL to_pulse: got t=%b g=%b exp 1 00", timeout_err, grant);
    end
    tick;
    nchk++;
    if (grant !== 2'b10 || timeout_err !== 1'b0) begin
      nerr++;
      $display("FAIL to_ptr: got g=%b t=%b exp 10 0", grant, timeout_err);
    end
  endtask

  task automatic test_reset_mid_resp;
    a_waitrequest = 1'b0;
    tick;
    nchk++;
    if (grant !== 2'b10 || a_read !== 1'b0) begin
      nerr++;
      $display("FAIL rr_resp: got g=%b r=%b exp 10 0", grant, a_read);
    end
    #2;
    reset = 1'b1;
    #1;
    nchk++;
    if ({grant, a_read, timeout_err, h_readdatavalid} !== 6'b0
        || h_waitrequest !== 2'b11) begin
      nerr++;
      $display("FAIL rr_async: got g=%b r=%b t=%b v=%b w=%b",
               grant, a_read, timeout_err, h_readdatavalid, h_waitrequest);
    end
    tick;
    tick;
    reset = 1'b0;
    #1;
    nchk++;
    if (grant !== 2'b00) begin
      nerr++;
      $display("FAIL rr_rel: got g=%b exp 00", grant);
    end
    a_readdatavalid = 1'b1;
    a_readdata = 32'hCAFE_0001;
    tick;
    nchk++;
    if (grant !== 2'b01 || a_read !== 1'b1 || a_address !== 32'h300) begin
      nerr++;
      $display("FAIL rr_ptr0: got g=%b r=%b a=%h exp 01 1 300",
               grant, a_read, a_address);
    end
    nchk++;
    if (h_readdatavalid !== 2'b01 || h_readdata !== 32'hCAFE_0001) begin
      nerr++;
      $display("FAIL rr_data: got v=%b d=%h exp 01 cafe0001",
               h_readdatavalid, h_readdata);
    end
    tick;
    h_read = 2'b00;
    a_readdatavalid = 1'b0;
    #1;
    nchk++;
    if (grant !== 2'b00) begin
      nerr++;
      $display("FAIL rr_done: got g=%b exp 00", grant);
    end
  endtask

  task automatic test_rw_both;
    h_read = 2'b01;
    h_write = 2'b01;
    h_address[31:0] = 32'h0000_0600;
    a_waitrequest = 1'b0;
    a_readdatavalid = 1'b0;
    tick;
    nchk++;
    if ({a_write, a_read} !== 2'b10 || grant !== 2'b01
        || h_readdatavalid !== 2'b00) begin
      nerr++;
      $display("FAIL rw_cmd: got w=%b r=%b g=%b v=%b exp 1 0 01 00",
               a_write, a_read, grant, h_readdatavalid);
    end
    tick;
    h_read = 2'b00;
    h_write = 2'b00;
    a_readdatavalid = 1'b1;
    a_readdata = 32'h5555_AAAA;
    #1;
    nchk++;
    if (h_readdatavalid !== 2'b00 || h_readdata !== 32'h0 || grant !== 2'b00) begin
      nerr++;
      $display("FAIL rw_late: got v=%b d=%h g=%b exp 00 0 00",
               h_readdatavalid, h_readdata, grant);
    end
    tick;
    a_readdatavalid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    h_address = '0;
    h_byteenable = '0;
    h_read = '0;
    h_write = '0;
    h_writedata = '0;
    a_waitrequest = 1'b0;
    a_readdata = '0;
    a_readdatavalid = 1'b0;
    #1;
    test_reset;
    test_alternate;
    test_write;
    test_stall;
    test_timeout;
    test_reset_mid_resp;
    test_rw_both;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
